// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder
// ----------------------------------------------------------------------------
// Instruction-memory side of the fetch interface. Fetch presents a byte PC;
// the word is read from a small word-addressed RAM (or flagged as a fault),
// carried down a fixed-length pipeline and dropped into a response queue that
// decode drains under its own backpressure. A flush discards everything in
// flight or queued so a redirected fetch stream starts clean. The RAM is
// filled through a separate load port.
//
// Parameters
//   DEPTH      instruction words stored (power of 2, >= 2)
//   LATENCY    cycles from request accept to earliest rsp_valid (1..4)
//   RSP_DEPTH  response queue entries (>= LATENCY)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid_F  fetch presents a request
//   req_addr_F   byte address (PC) of the instruction
//   req_ready    request accepted when req_valid_F && req_ready
//   flush        drop all in-flight and queued responses
//   rsp_valid    rsp_* fields valid
//   rsp_ready    consumer takes the response when rsp_valid && rsp_ready
//   rsp_instr    instruction word (0 on fault)
//   rsp_addr     PC of the request this response answers
//   rsp_fault    misaligned PC or PC beyond the end of the RAM
//   ld_en        write ld_data into word ld_addr at the clock edge
//   ld_addr      word index for load
//   ld_data      word to load
// ============================================================================
module imem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_F,
    input  logic [63:0]              req_addr_F,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [63:0]              rsp_addr,
    output logic                     rsp_fault,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Pointer width; a single-entry queue still needs a 1-bit pointer.
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    // Occupancy width: wide enough for in-flight stages plus a full queue.
    localparam int unsigned OW = $clog2(RSP_DEPTH + LATENCY + 1);

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        fault;
    } rsp_entry_t;

    // ------------------------------------------------------------------------
    // Instruction RAM
    // ------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    // NOTE: the RAM has no reset; its contents must survive reset, and a
    // resettable array would also prevent it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------------
    // Request accept and read
    // ------------------------------------------------------------------------
    logic            acc;
    logic            misaligned;
    logic            out_of_range;
    logic [AW-1:0]   rd_idx;
    rsp_entry_t      acc_entry;
    logic [OW-1:0]   inflight;
    logic [OW-1:0]   count_q;
    logic [OW-1:0]   occupancy;

    // Credits come from registered state only, so req_ready never depends
    // on req_valid_F or rsp_ready within the same cycle.
    assign occupancy = inflight + count_q;
    assign req_ready = (occupancy < OW'(RSP_DEPTH));
    assign acc       = req_valid_F && req_ready;

    assign rd_idx       = req_addr_F[2 +: AW];
    assign misaligned   = |req_addr_F[1:0];
    assign out_of_range = |req_addr_F[63:2+AW];

    // The read happens in the accept cycle, before any same-edge load lands,
    // so a coincident load is seen only by later requests.
    always_comb begin
        // NOTE: every field gets a value on every path so no latch is inferred.
        acc_entry.addr  = req_addr_F;
        acc_entry.fault = misaligned || out_of_range;
        acc_entry.instr = 32'h0;
        if (!(misaligned || out_of_range)) begin
            acc_entry.instr = mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: LATENCY-1 registered stages between accept and queue.
    // ------------------------------------------------------------------------
    logic       push_v;
    rsp_entry_t push_entry;

    if (LATENCY > 1) begin : g_pipe
        localparam int unsigned NSTG = LATENCY - 1;

        logic [NSTG-1:0] stg_valid_q;
        rsp_entry_t      stg_data_q [NSTG];

        // A request accepted in the flush cycle belongs to the new stream and
        // is kept; everything older is dropped.
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stg_valid_q <= '0;
            end else begin
                stg_valid_q[0] <= acc;
                for (int i = 1; i < int'(NSTG); i++) begin
                    stg_valid_q[i] <= stg_valid_q[i-1] && !flush;
                end
            end
        end

        // Payload is qualified by the valid bits, so it carries no reset.
        always_ff @(posedge clk) begin
            if (acc) begin
                stg_data_q[0] <= acc_entry;
            end
            for (int i = 1; i < int'(NSTG); i++) begin
                stg_data_q[i] <= stg_data_q[i-1];
            end
        end

        assign push_v     = stg_valid_q[NSTG-1] && !flush;
        assign push_entry = stg_data_q[NSTG-1];
        assign inflight   = OW'($countones(stg_valid_q));
    end else begin : g_nopipe
        // Single-cycle latency: the read result goes straight into the queue.
        assign push_v     = acc;
        assign push_entry = acc_entry;
        assign inflight   = '0;
    end

    // ------------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------------
    rsp_entry_t    q_mem [RSP_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_idx;
    logic          pop;
    rsp_entry_t    head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    // On flush the queue restarts at slot 0; only a surviving push lands.
    assign wr_idx = flush ? '0 : wr_ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_v ? next_ptr('0) : '0;
            count_q  <= OW'(push_v);
        end else begin
            if (push_v) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + OW'(push_v) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_v) begin
            q_mem[wr_idx] <= push_entry;
        end
    end

    // Outputs read zero whenever nothing is valid, including straight out of
    // reset, even though the queue storage itself is not reset.
    assign head      = q_mem[rd_ptr_q];
    assign rsp_instr = rsp_valid ? head.instr : 32'h0;
    assign rsp_addr  = rsp_valid ? head.addr  : 64'h0;
    assign rsp_fault = rsp_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// ============================================================================
// tb_imem_responder
// ----------------------------------------------------------------------------
// Directed scenarios followed by a randomized phase. A transaction-level model
// (ordered list of outstanding requests, a shadow copy of the RAM) predicts
// req_ready, rsp_valid and the response fields every cycle.
// ============================================================================
module tb_imem_responder;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned RSP_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid_F;
    logic [63:0] req_addr_F;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [63:0] rsp_addr;
    logic        rsp_fault;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    imem_responder #(
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_F(req_valid_F),
        .req_addr_F (req_addr_F),
        .req_ready  (req_ready),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_addr   (rsp_addr),
        .rsp_fault  (rsp_fault),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          cyc;
    } txn_t;

    txn_t        exp_q[$];   // accepted, not yet delivered or flushed
    txn_t        log_q[$];   // observed deliveries, cyc = delivery cycle
    logic [31:0] model_mem [DEPTH];
    int          now;
    logic        last_acc;
    int          n_assert;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t predict(input logic [63:0] a, input int c);
        txn_t t;
        t.addr  = a;
        t.fault = (a % 4 != 0) || (a >= 64'(DEPTH * 4));
        t.instr = t.fault ? 32'h0 : model_mem[a / 4];
        t.cyc   = c;
        return t;
    endfunction

    // Called at a falling edge with inputs already driven; checks outputs,
    // updates the model with this cycle's handshakes, advances one cycle.
    task automatic cycle();
        logic acc;
        logic pop;
        logic exp_valid;
        txn_t o;
        check("req_ready", req_ready, (exp_q.size() < RSP_DEPTH));
        exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + int'(LATENCY) <= now);
        check("rsp_valid", rsp_valid, exp_valid);
        if (rsp_valid && exp_valid) begin
            check("rsp_instr", rsp_instr, exp_q[0].instr);
            check("rsp_addr",  rsp_addr,  exp_q[0].addr);
            check("rsp_fault", rsp_fault, exp_q[0].fault);
        end
        acc = req_valid_F && req_ready;
        pop = rsp_valid && rsp_ready;
        if (pop) begin
            o.addr  = rsp_addr;
            o.instr = rsp_instr;
            o.fault = rsp_fault;
            o.cyc   = now;
            log_q.push_back(o);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        if (acc) exp_q.push_back(predict(req_addr_F, now));
        if (ld_en) model_mem[ld_addr] = ld_data;
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_log(input int i, input string tag, input logic [31:0] instr,
                             input logic [63:0] addr, input logic fault);
        check({tag, " present"}, 64'(log_q.size() > i), 64'(1));
        if (log_q.size() > i) begin
            check({tag, " instr"}, log_q[i].instr, instr);
            check({tag, " addr"},  log_q[i].addr,  addr);
            check({tag, " fault"}, log_q[i].fault, fault);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t1;
        int n_acc;
        logic [63:0] a;
        n_assert    = 0;
        n_fail      = 0;
        now         = 0;
        last_acc    = 1'b0;
        // NOTE: inputs are driven with blocking assignments between clock
        // edges so the DUT never races the stimulus.
        reset       = 1'b0;
        req_valid_F = 1'b0;
        req_addr_F  = '0;
        flush       = 1'b0;
        rsp_ready   = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 'x;

        repeat (2) @(negedge clk);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_instr", rsp_instr, 0);
        check("reset rsp_addr",  rsp_addr,  0);
        check("reset rsp_fault", rsp_fault, 0);
        reset = 1'b1;
        #1;
        check("reset req_ready", req_ready, 1);
        @(negedge clk);

        // Preload words 0..3 = A0..A3, word 8 = C8.
        for (int i = 0; i < 5; i++) begin
            ld_en   = 1'b1;
            ld_addr = (i == 4) ? 6'd8 : 6'(i);
            ld_data = (i == 4) ? 32'hC8 : 32'hA0 + 32'(i);
            cycle();
        end
        ld_en = 1'b0;

        // 1: back-to-back requests, full throughput.
        log_q.delete();
        rsp_ready   = 1'b1;
        req_valid_F = 1'b1;
        t1 = now;
        for (int i = 0; i < 3; i++) begin
            req_addr_F = 64'(i * 4);
            cycle();
        end
        req_valid_F = 1'b0;
        idle(4);
        for (int i = 0; i < 3; i++) begin
            check_log(i, "t1 rsp", 32'hA0 + 32'(i), 64'(i * 4), 1'b0);
            if (log_q.size() > i) check("t1 cycle", 64'(log_q[i].cyc), 64'(t1 + 2 + i));
        end

        // 2: backpressure fills exactly RSP_DEPTH credits.
        log_q.delete();
        rsp_ready   = 1'b0;
        req_valid_F = 1'b1;
        req_addr_F  = 64'h0;
        n_acc       = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_acc) begin
                n_acc++;
                req_addr_F = req_addr_F + 64'h4;
            end
        end
        check("t2 accepted", 64'(n_acc), 64'(RSP_DEPTH));
        check("t2 req_ready full", req_ready, 0);
        req_valid_F = 1'b0;
        rsp_ready   = 1'b1;
        idle(6);
        for (int i = 0; i < 4; i++) check_log(i, "t2 rsp", 32'hA0 + 32'(i), 64'(i * 4), 1'b0);
        check("t2 req_ready drained", req_ready, 1);

        // 3: misaligned and out-of-range faults.
        log_q.delete();
        req_valid_F = 1'b1;
        req_addr_F  = 64'h2;
        cycle();
        req_addr_F  = 64'h100;
        cycle();
        req_valid_F = 1'b0;
        idle(5);
        check_log(0, "t3 misaligned", 32'h0, 64'h2, 1'b1);
        check_log(1, "t3 range", 32'h0, 64'h100, 1'b1);

        // 4: flush with a new request in the same cycle.
        log_q.delete();
        rsp_ready   = 1'b0;
        req_valid_F = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr_F = 64'(i * 4);
            cycle();
        end
        flush      = 1'b1;
        req_addr_F = 64'h20;
        cycle();
        flush       = 1'b0;
        req_valid_F = 1'b0;
        rsp_ready   = 1'b1;
        idle(6);
        check("t4 count", 64'(log_q.size()), 64'd1);
        check_log(0, "t4 rsp", 32'hC8, 64'h20, 1'b0);

        // 5: load and read of the same word in the same cycle.
        log_q.delete();
        ld_en       = 1'b1;
        ld_addr     = 6'd1;
        ld_data     = 32'hBEEF;
        req_valid_F = 1'b1;
        req_addr_F  = 64'h4;
        cycle();
        ld_en = 1'b0;
        cycle();
        req_valid_F = 1'b0;
        idle(5);
        check_log(0, "t5 old", 32'hA1, 64'h4, 1'b0);
        check_log(1, "t5 new", 32'hBEEF, 64'h4, 1'b0);

        // 6: asynchronous reset while a response is pending.
        log_q.delete();
        rsp_ready   = 1'b0;
        req_valid_F = 1'b1;
        req_addr_F  = 64'h0;
        cycle();
        req_valid_F = 1'b0;
        idle(2);
        check("t6 valid before reset", rsp_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6 async rsp_valid", rsp_valid, 0);
        check("t6 async rsp_instr", rsp_instr, 0);
        check("t6 async rsp_addr",  rsp_addr,  0);
        check("t6 async rsp_fault", rsp_fault, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        now++;
        #1;
        check("t6 req_ready after release", req_ready, 1);
        rsp_ready   = 1'b1;
        req_valid_F = 1'b1;
        req_addr_F  = 64'h0;
        cycle();
        req_valid_F = 1'b0;
        idle(4);
        check_log(0, "t6 mem intact", 32'hA0, 64'h0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req_valid_F = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) begin
                a = {$urandom(), $urandom()};
                if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, 255)) | 64'h1;
            end else begin
                a = 64'($urandom_range(0, DEPTH - 1)) * 4;
            end
            req_addr_F = a;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            ld_en      = ($urandom_range(0, 4) == 0);
            ld_addr    = 6'($urandom_range(0, DEPTH - 1));
            ld_data    = $urandom();
            cycle();
        end
        req_valid_F = 1'b0;
        flush       = 1'b0;
        ld_en       = 1'b0;
        rsp_ready   = 1'b1;
        idle(10);
        check("final rsp_valid", rsp_valid, 0);
        check("final req_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
